// File: rtl/d_latch_opt_pkg.sv
// Shared constants and gate helpers for the d_latch_opt latch bank.
// IMPL selects between the behavioural latch and the NAND-cell implementation.
package d_latch_opt_pkg;

  localparam int IMPL_BEHAV = 0;
  localparam int IMPL_GATE  = 1;

  // Two-input NAND: the only primitive the gate-level cell is built from.
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/d_latch_opt_cell.sv
// One-bit gated-D latch built from NAND gates, with a reset-forcing stage.
// During reset the gate is held open and the data path is steered to rst_val.
module d_latch_cell
  import d_latch_opt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic qbar
);

  logic clk_n_s;
  logic rst_s;
  logic en_s;
  logic d_gated_n_s;
  logic rv_gated_n_s;
  logic din_s;
  logic din_n_s;
  logic set_n_s;
  logic clr_n_s;
  logic state_q;

  // Enable is forced open while reset is active: en = clk | ~rst_n.
  assign clk_n_s      = nand2(clk, clk);
  assign rst_s        = nand2(rst_n, rst_n);
  assign en_s         = nand2(clk_n_s, rst_n);

  // Data mux: d in normal operation, rst_val while reset is active.
  assign d_gated_n_s  = nand2(d, rst_n);
  assign rv_gated_n_s = nand2(rst_val, rst_s);
  assign din_s        = nand2(d_gated_n_s, rv_gated_n_s);
  assign din_n_s      = nand2(din_s, din_s);

  // Set and clear are derived from complementary data, so they are never both active.
  assign set_n_s      = nand2(din_s, en_s);
  assign clr_n_s      = nand2(din_n_s, en_s);

  // Storage node: set/clear pulses update it, otherwise it holds.
  always_latch begin
    if (!set_n_s) begin
      state_q <= 1'b1;
    end else if (!clr_n_s) begin
      state_q <= 1'b0;
    end
  end

  assign q    = state_q;
  assign qbar = ~state_q;

endmodule

// File: rtl/d_latch_opt.sv
// Level-sensitive D latch bank with complementary outputs and async active-low reset.
// IMPL selects a behavioural latch or one NAND-built d_latch_cell per bit.
module d_latch_opt
  import d_latch_opt_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               IMPL    = IMPL_BEHAV,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  if (IMPL == IMPL_GATE) begin : g_gate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_latch_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (RST_VAL[i]),
        .d       (d[i]),
        .q       (q[i]),
        .qbar    (qbar[i])
      );
    end
  end else begin : g_behav
    logic [WIDTH-1:0] lat_q;

    // Latch with async preset/clear: reset dominates, transparent while clk is high.
    always_latch begin
      if (!rst_n) begin
        lat_q <= RST_VAL;
      end else if (clk) begin
        lat_q <= d;
      end
    end

    // qbar is derived from the single storage node so it can never equal q.
    assign q    = lat_q;
    assign qbar = ~lat_q;
  end

endmodule

// File: tb/tb_d_latch_opt.sv
// Bench for d_latch_opt: a 1-bit default instance plus 8-bit behavioural and gate-level twins.
module tb_d_latch_opt;
  import d_latch_opt_pkg::*;

  localparam logic [7:0] RSTV8 = 8'hC3;

  logic       clk;
  logic       rst_n;
  logic [0:0] d1;
  logic [0:0] q1, qb1;
  logic [7:0] d8;
  logic [7:0] qa, qba, qg, qbg;

  int n_tests;
  int n_fail;

  logic       m1;
  logic [7:0] m8;

  d_latch_opt u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .q(q1), .qbar(qb1)
  );

  d_latch_opt #(.WIDTH(8), .IMPL(IMPL_BEHAV), .RST_VAL(RSTV8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .d(d8), .q(qa), .qbar(qba)
  );

  d_latch_opt #(.WIDTH(8), .IMPL(IMPL_GATE), .RST_VAL(RSTV8)) u_dut_g (
    .clk(clk), .rst_n(rst_n), .d(d8), .q(qg), .qbar(qbg)
  );

  typedef struct {
    logic       rst_n;
    logic       clk;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: reset forces the reset value, an open gate copies d, a closed gate keeps the value.
  task automatic update_model();
    if (!rst_n) begin
      m1 = 1'b0;
      m8 = RSTV8;
    end else if (clk) begin
      m1 = d1[0];
      m8 = d8;
    end
  endtask

  task automatic settle_check(input string name);
    update_model();
    #1;
    check({name, ".q1"},    {7'd0, q1[0]},  {7'd0, m1});
    check({name, ".qb1"},   {7'd0, qb1[0]}, {7'd0, ~m1});
    check({name, ".qa"},    qa,  m8);
    check({name, ".qba"},   qba, ~m8);
    check({name, ".qg"},    qg,  m8);
    check({name, ".qbg"},   qbg, ~m8);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;
    #1;

    // Reset held while clk and d toggle: outputs pinned to the reset value.
    for (int i = 0; i < 8; i++) begin
      clk = ~clk;
      #2;
      d1 = ~d1;
      d8 = ~d8;
      #1;
      check("rst_hold.q1",  {7'd0, q1[0]},  8'h00);
      check("rst_hold.qb1", {7'd0, qb1[0]}, 8'h01);
      check("rst_hold.qa",  qa,  RSTV8);
      check("rst_hold.qg",  qg,  RSTV8);
      check("rst_hold.qbg", qbg, ~RSTV8);
    end
    clk = 1'b0;
    #1;

    // Directed vector table (8-bit instances, constant expectations).
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'hC3};
    vecs[1]  = '{1'b1, 1'b0, 8'h11, 8'hC3};
    vecs[2]  = '{1'b1, 1'b1, 8'h11, 8'h11};
    vecs[3]  = '{1'b1, 1'b1, 8'hA5, 8'hA5};
    vecs[4]  = '{1'b1, 1'b0, 8'hA5, 8'hA5};
    vecs[5]  = '{1'b1, 1'b0, 8'h5A, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 8'hA5};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 8'hC3};
    vecs[8]  = '{1'b1, 1'b0, 8'hFF, 8'hC3};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 8'hC3};
    vecs[11] = '{1'b1, 1'b1, 8'h0F, 8'h0F};
    vecs[12] = '{1'b1, 1'b0, 8'h0F, 8'h0F};
    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n;
      clk   = vecs[i].clk;
      d8    = vecs[i].d;
      d1    = vecs[i].d[0];
      update_model();
      #2;
      check($sformatf("vec%0d.qa", i),  qa,  vecs[i].exp);
      check($sformatf("vec%0d.qba", i), qba, ~vecs[i].exp);
      check($sformatf("vec%0d.qg", i),  qg,  vecs[i].exp);
      check($sformatf("vec%0d.qbg", i), qbg, ~vecs[i].exp);
    end

    // Hold: capture 1, then d wiggles with the gate closed.
    clk = 1'b1; d1 = 1'b1; d8 = 8'h3C;
    settle_check("hold_cap");
    clk = 1'b0;
    settle_check("hold_close");
    d1 = 1'b0; d8 = 8'h00; settle_check("hold_d0");
    d1 = 1'b1; d8 = 8'hFF; settle_check("hold_d1");
    d1 = 1'b0; d8 = 8'h81; settle_check("hold_d2");
    check("hold_const.q1", {7'd0, q1[0]}, 8'h01);
    check("hold_const.qa", qa, 8'h3C);

    // Reset mid-phase with clk high, then release with clk still high.
    clk = 1'b1; d1 = 1'b1; d8 = 8'h66;
    settle_check("midrst_pre");
    #3;
    rst_n = 1'b0;
    settle_check("midrst_on");
    check("midrst_on.q1", {7'd0, q1[0]}, 8'h00);
    #3;
    rst_n = 1'b1;
    settle_check("midrst_off");
    check("midrst_off.q1", {7'd0, q1[0]}, 8'h01);
    check("midrst_off.qg", qg, 8'h66);

    // Free-running clk with d flipping mid-phase.
    clk = 1'b0;
    settle_check("run_init");
    for (int i = 0; i < 10; i++) begin
      #4;
      clk = ~clk;
      settle_check("run_edge");
      #4;
      d1 = ~d1;
      d8 = d8 + 8'h35;
      settle_check("run_mid");
    end

    // Random single-input changes, never d together with a clk edge.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        clk = ~clk;
      end else if (sel < 8) begin
        d8 = 8'($urandom);
        d1 = 1'($urandom);
      end else begin
        rst_n = ~rst_n;
      end
      #1;
      settle_check("rand");
      check("rand.twin", qg, qa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
